// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions for the message schedule datapath.
//   WORD_W / BLK_WORDS / ROUNDS : fixed geometry of the schedule
//   CNT_W / T_W                 : widths of the load counter and round index
//   state_e                     : schedule controller state encoding
//   ror / shr                   : rotate-right and shift-right primitives
package sha256_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned BLK_WORDS = 16;
   localparam int unsigned ROUNDS    = 64;
   localparam int unsigned CNT_W     = $clog2(BLK_WORDS);
   localparam int unsigned T_W       = $clog2(ROUNDS);

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      StLoad = 1'b0,
      StRun  = 1'b1
   } state_e;

   // n must lie in 1..WORD_W-1.
   function automatic word_t ror(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic word_t shr(input word_t x, input int unsigned n);
      return x >> n;
   endfunction

endpackage

// File: rtl/lsigma0.sv
// SHA-256 lowercase sigma0: ROTR7 ^ ROTR18 ^ SHR3.
//   x_i : input word
//   y_o : sigma0(x_i), purely combinational
module lsigma0
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] x_i,
   output logic [WORD_W-1:0] y_o
);

   assign y_o = ror(x_i, 7) ^ ror(x_i, 18) ^ shr(x_i, 3);

endmodule

// File: rtl/lsigma1.sv
// SHA-256 lowercase sigma1: ROTR17 ^ ROTR19 ^ SHR10.
//   x_i : input word
//   y_o : sigma1(x_i), purely combinational
module lsigma1
   import sha256_pkg::*;
(
   input  logic [WORD_W-1:0] x_i,
   output logic [WORD_W-1:0] y_o
);

   assign y_o = ror(x_i, 17) ^ ror(x_i, 19) ^ shr(x_i, 10);

endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message schedule controller.
// Loads one 16-word block, then emits W[0..63] one per output handshake,
// expanding W[16..63] in place in a 16-entry circular buffer.
//   clk, rst           : clock, synchronous active-high reset
//   abort              : synchronous discard of the current block
//   in_valid/in_ready  : message word handshake, in_word is M[0] first
//   out_valid/out_ready: schedule word handshake
//   out_word, out_t    : W[t] and its round index t (combinational from buffer)
//   done               : one-cycle pulse after W[63] is accepted
module msg_schedule
   import sha256_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_word,
   output logic [T_W-1:0]    out_t,
   output logic              done
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [T_W-1:0]   t_q, t_d;
   logic             done_q, done_d;

   word_t            wbuf_q [BLK_WORDS];
   logic             wbuf_we;
   logic [CNT_W-1:0] wbuf_waddr;
   word_t            wbuf_wdata;

   // Buffer slot t%16 currently holds W[t-16]; the other taps follow from
   // W[t-2], W[t-7], W[t-15] living at (t+14), (t+9), (t+1) mod 16.
   logic [CNT_W-1:0] idx_t, idx_m2, idx_m7, idx_m15;
   logic             expand;
   word_t            s0_out, s1_out, w_exp;

   assign idx_t   = t_q[CNT_W-1:0];
   assign idx_m2  = idx_t + CNT_W'(14);
   assign idx_m7  = idx_t + CNT_W'(9);
   assign idx_m15 = idx_t + CNT_W'(1);
   assign expand  = (t_q[T_W-1:CNT_W] != '0);

   lsigma0 u_lsigma0 (
      .x_i (wbuf_q[idx_m15]),
      .y_o (s0_out)
   );

   lsigma1 u_lsigma1 (
      .x_i (wbuf_q[idx_m2]),
      .y_o (s1_out)
   );

   assign w_exp = s1_out + wbuf_q[idx_m7] + s0_out + wbuf_q[idx_t];

   assign out_word  = expand ? w_exp : wbuf_q[idx_t];
   assign out_t     = t_q;
   assign in_ready  = (state_q == StLoad);
   assign out_valid = (state_q == StRun);
   assign done      = done_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      t_d        = t_q;
      done_d     = 1'b0;
      wbuf_we    = 1'b0;
      wbuf_waddr = cnt_q;
      wbuf_wdata = in_word;

      unique case (state_q)
         StLoad: begin
            if (in_valid) begin
               wbuf_we = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(BLK_WORDS - 1)) begin
                  state_d = StRun;
                  t_d     = '0;
               end
            end
         end
         StRun: begin
            if (out_ready) begin
               // Expanded words overwrite W[t-16], which is no longer needed.
               wbuf_we    = expand;
               wbuf_waddr = idx_t;
               wbuf_wdata = w_exp;
               t_d        = t_q + T_W'(1);
               if (t_q == T_W'(ROUNDS - 1)) begin
                  state_d = StLoad;
                  cnt_d   = '0;
                  t_d     = '0;
                  done_d  = 1'b1;
               end
            end
         end
      endcase

      // Abort wins over any handshake in the same cycle.
      if (abort) begin
         state_d = StLoad;
         cnt_d   = '0;
         t_d     = '0;
         done_d  = 1'b0;
         wbuf_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StLoad;
         cnt_q   <= '0;
         t_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         done_q  <= done_d;
      end
   end

   // Buffer has no reset; contents are only meaningful after a full load.
   always_ff @(posedge clk) begin
      if (wbuf_we && !rst) begin
         wbuf_q[wbuf_waddr] <= wbuf_wdata;
      end
   end

endmodule

// File: tb/tb_msg_schedule.sv
module tb_msg_schedule;

   logic        clk = 1'b0;
   logic        rst, abort, in_valid, out_ready;
   logic        in_ready, out_valid, done;
   logic [31:0] in_word, out_word;
   logic [5:0]  out_t;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] blk   [16];
   logic [31:0] ref_w [64];
   logic [31:0] hand  [4];
   bit          use_hand;

   always #5 clk = ~clk;

   msg_schedule dut (
      .clk       (clk),
      .rst       (rst),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_t     (out_t),
      .done      (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // Straight 64-entry expansion, independent of any circular indexing.
   task automatic build_ref();
      for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
      for (int t = 16; t < 64; t++)
         ref_w[t] = sig1(ref_w[t-2]) + ref_w[t-7] + sig0(ref_w[t-15]) + ref_w[t-16];
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      build_ref();
   endtask

   task automatic set_pattern(input logic [31:0] seed);
      for (int i = 0; i < 16; i++) blk[i] = 32'((i + 1) * 32'h9E3779B9) ^ seed;
      build_ref();
   endtask

   // Called at posedge+#1; returns at posedge+#1 after the 16th handshake.
   task automatic load_block(input bit gaps, input bit expect_done);
      int   idx = 0;
      int   cyc = 0;
      logic rdy;
      while (idx < 16 && cyc < 200) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_word  = blk[idx];
         @(negedge clk);
         rdy = in_ready;
         check("load_in_ready", 32'(in_ready), 32'd1);
         check("load_out_valid", 32'(out_valid), 32'd0);
         if (expect_done && cyc == 0) check("b2b_done", 32'(done), 32'd1);
         @(posedge clk);
         if (in_valid && rdy) idx++;
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      if (idx < 16) check("load_timeout", 32'(idx), 32'd16);
   endtask

   // kill_mode: 0 abort, 1 rst, 2 rst+abort; kill_at < 0 disables.
   task automatic collect_block(input bit stall, input int kill_at, input int kill_mode);
      int t = 0;
      int cyc = 0;
      while (t < 64 && cyc < 1000) begin
         out_ready = stall ? 1'($urandom_range(0, 3) != 0) : 1'b1;
         if (t == kill_at) begin
            out_ready = 1'b1;
            abort     = (kill_mode != 1);
            rst       = (kill_mode != 0);
         end
         @(negedge clk);
         check("run_out_valid", 32'(out_valid), 32'd1);
         check("run_in_ready", 32'(in_ready), 32'd0);
         check("run_out_t", 32'(out_t), 32'(t));
         check($sformatf("W%0d", t), out_word, ref_w[t]);
         if (use_hand && t >= 16 && t < 20)
            check($sformatf("nist_W%0d", t), out_word, hand[t-16]);
         @(posedge clk);
         if (t == kill_at) begin
            #1;
            abort     = 1'b0;
            rst       = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            check("kill_out_valid", 32'(out_valid), 32'd0);
            check("kill_in_ready", 32'(in_ready), 32'd1);
            check("kill_out_t", 32'(out_t), 32'd0);
            check("kill_done", 32'(done), 32'd0);
            @(posedge clk);
            #1;
            return;
         end
         if (out_ready) t++;
         #1;
         cyc++;
      end
      out_ready = 1'b0;
      if (t < 64) check("run_timeout", 32'(t), 32'd64);
   endtask

   task automatic check_done_tail();
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd1);
      check("done_out_valid", 32'(out_valid), 32'd0);
      check("done_out_t", 32'(out_t), 32'd0);
      @(negedge clk);
      check("done_single", 32'(done), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      hand[0] = 32'h61626380;
      hand[1] = 32'h000F0000;
      hand[2] = 32'h7DA86405;
      hand[3] = 32'h600003C6;
      use_hand  = 1'b0;
      rst       = 1'b1;
      abort     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_word   = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_out_t", 32'(out_t), 32'd0);
      @(posedge clk);
      #1;

      // NIST "abc", no gaps, no stalls, hand-computed W16..W19.
      set_abc();
      use_hand = 1'b1;
      load_block(1'b0, 1'b0);
      collect_block(1'b0, -1, 0);
      check_done_tail();

      // Input gaps and output backpressure.
      load_block(1'b1, 1'b0);
      collect_block(1'b1, -1, 0);
      check_done_tail();
      use_hand = 1'b0;

      // Back-to-back: block B offered in block A's done cycle.
      set_pattern(32'h5A5A0000);
      load_block(1'b0, 1'b0);
      collect_block(1'b0, -1, 0);
      set_pattern(32'hDEADBEEF);
      load_block(1'b0, 1'b1);
      collect_block(1'b1, -1, 0);
      check_done_tail();

      // Abort at t=40, then a fresh "abc".
      set_abc();
      load_block(1'b0, 1'b0);
      collect_block(1'b0, 40, 0);
      load_block(1'b0, 1'b0);
      collect_block(1'b0, -1, 0);
      check_done_tail();

      // Reset mid-LOAD after 7 handshakes.
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_word  = 32'hFFFF0000 | 32'(i);
         @(posedge clk);
         #1;
      end
      rst     = 1'b1;
      in_word = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("rstload_in_ready", 32'(in_ready), 32'd1);
      check("rstload_out_valid", 32'(out_valid), 32'd0);
      check("rstload_out_t", 32'(out_t), 32'd0);
      check("rstload_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      set_pattern(32'h13572468);
      load_block(1'b0, 1'b0);
      collect_block(1'b0, -1, 0);
      check_done_tail();

      // Reset mid-RUN at t=20, then reset together with abort at t=33.
      set_abc();
      load_block(1'b0, 1'b0);
      collect_block(1'b0, 20, 1);
      load_block(1'b1, 1'b0);
      collect_block(1'b1, 33, 2);
      load_block(1'b0, 1'b0);
      collect_block(1'b0, -1, 0);
      check_done_tail();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
